// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: ALU op encodings, FSM state type, multiply length.
// Also provides the single-cycle ALU function used by the stage.
package exec_pkg;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

  // Unused codes (and MUL, which has its own datapath) return zero.
  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier, one multiplier bit per i_step cycle; o_product is the
// accumulator including the current step, so it is final on the cycle o_done is high.
module iterative_multiplier #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_step,
  input  logic         i_last,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_product
);

  logic [W-1:0] r_acc;
  logic [W-1:0] r_mcand;
  logic [W-1:0] r_mplier;
  logic [W-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_acc_nxt;
  assign o_done    = i_step && i_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (i_step) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU (latency 1) plus a 32-cycle iterative multiply.
// Valid/ready handshake; output register holds while o_valid && !i_out_ready.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_alu_op,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [4:0]        i_rd,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic              i_is_write,
  input  logic              i_flush,
  input  logic              i_out_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_write_data,
  output logic [4:0]        o_rd,
  output logic              o_is_load,
  output logic              o_is_store,
  output logic              o_is_write,
  output logic              o_busy
);

  state_e            r_state, w_state_nxt;
  logic [4:0]        r_cnt, w_cnt_nxt;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_result, r_wdata;
  logic [4:0]        r_rd;
  logic              r_ld, r_st, r_wr;
  logic [DATA_W-1:0] r_mul_wdata;
  logic [4:0]        r_mul_rd;
  logic              r_mul_ld, r_mul_st, r_mul_wr;
  logic              w_accept, w_is_mul, w_mul_start, w_mul_step, w_last, w_mul_done;
  logic [DATA_W-1:0] w_product, w_alu;

  assign o_ready     = rst_n && (r_state == ST_IDLE) && (!r_out_vld || i_out_ready) && !i_flush;
  assign w_accept    = i_valid && o_ready;
  assign w_is_mul    = (i_alu_op == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_mul_step  = (r_state == ST_MUL_RUN);
  assign w_last      = (r_cnt == 5'(MUL_CYCLES - 1));
  assign w_alu       = alu_calc(i_alu_op, i_operand_a, i_operand_b);

  iterative_multiplier #(.W(DATA_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_step    (w_mul_step),
    .i_last    (w_last),
    .i_a       (i_operand_a),
    .i_b       (i_operand_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mul_start) begin
          w_state_nxt = ST_MUL_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_MUL_RUN: begin
        w_cnt_nxt = r_cnt + 5'd1;
        if (w_mul_done) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pass-through fields of an accepted MUL wait here until the product is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_wdata <= '0;
      r_mul_rd    <= '0;
      r_mul_ld    <= 1'b0;
      r_mul_st    <= 1'b0;
      r_mul_wr    <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_wdata <= i_store_data;
      r_mul_rd    <= i_rd;
      r_mul_ld    <= i_is_load;
      r_mul_st    <= i_is_store;
      r_mul_wr    <= i_is_write;
    end
  end

  // Control outputs are cleared whenever valid drops so the memory stage never sees stale commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_result  <= '0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_wr      <= 1'b0;
    end else if (i_flush) begin
      r_out_vld <= 1'b0;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_wr      <= 1'b0;
    end else if (w_mul_done) begin
      r_out_vld <= 1'b1;
      r_result  <= w_product;
      r_wdata   <= r_mul_wdata;
      r_rd      <= r_mul_rd;
      r_ld      <= r_mul_ld;
      r_st      <= r_mul_st;
      r_wr      <= r_mul_wr;
    end else if (w_accept && !w_is_mul) begin
      r_out_vld <= 1'b1;
      r_result  <= w_alu;
      r_wdata   <= i_store_data;
      r_rd      <= i_rd;
      r_ld      <= i_is_load;
      r_st      <= i_is_store;
      r_wr      <= i_is_write;
    end else if (r_out_vld && i_out_ready) begin
      r_out_vld <= 1'b0;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_wr      <= 1'b0;
    end
  end

  assign o_valid      = r_out_vld;
  assign o_alu_result = r_result;
  assign o_write_data = r_wdata;
  assign o_rd         = r_rd;
  assign o_is_load    = r_ld;
  assign o_is_store   = r_st;
  assign o_is_write   = r_wr;
  assign o_busy       = (r_state == ST_MUL_RUN);

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_alu_op = '0;
  logic [31:0] i_operand_a = '0;
  logic [31:0] i_operand_b = '0;
  logic [31:0] i_store_data = '0;
  logic [4:0]  i_rd = '0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic        i_is_write = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_out_ready = 1'b1;
  logic        o_valid;
  logic [31:0] o_alu_result;
  logic [31:0] o_write_data;
  logic [4:0]  o_rd;
  logic        o_is_load;
  logic        o_is_store;
  logic        o_is_write;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  execute_stage #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_alu_op     (i_alu_op),
    .i_operand_a  (i_operand_a),
    .i_operand_b  (i_operand_b),
    .i_store_data (i_store_data),
    .i_rd         (i_rd),
    .i_is_load    (i_is_load),
    .i_is_store   (i_is_store),
    .i_is_write   (i_is_write),
    .i_flush      (i_flush),
    .i_out_ready  (i_out_ready),
    .o_valid      (o_valid),
    .o_alu_result (o_alu_result),
    .o_write_data (o_write_data),
    .o_rd         (o_rd),
    .o_is_load    (o_is_load),
    .o_is_store   (o_is_store),
    .o_is_write   (o_is_write),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input logic ld, input logic st, input logic wr);
    i_valid      = 1'b1;
    i_alu_op     = op;
    i_operand_a  = a;
    i_operand_b  = b;
    i_store_data = sd;
    i_rd         = rd;
    i_is_load    = ld;
    i_is_store   = st;
    i_is_write   = wr;
  endtask

  task automatic test_reset();
    drive(4'd0, 32'h1, 32'h2, 32'h3, 5'd4, 1'b1, 1'b1, 1'b1);
    #3;
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    n_tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld_busy: got valid=%b busy=%b want 0 0", o_valid, o_busy);
    end
    n_tests++;
    if (o_alu_result !== 32'h0 || o_write_data !== 32'h0 || o_rd !== 5'd0 ||
        o_is_load !== 1'b0 || o_is_store !== 1'b0 || o_is_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h wd=%h rd=%0d ld=%b st=%b wr=%b want all 0",
               o_alu_result, o_write_data, o_rd, o_is_load, o_is_store, o_is_write);
    end
    tick();
    tick();
    // Still in reset across clock edges: nothing may have been accepted.
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got valid=%b want 0", o_valid); end
    i_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
  endtask

  task automatic test_add();
    i_out_ready = 1'b1;
    drive(4'd0, 32'h1000, 32'h24, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'h1024 || o_is_load !== 1'b1 || o_rd !== 5'd5) begin
      n_fail++;
      $display("FAIL add_result: got valid=%b res=%h ld=%b rd=%0d want 1 00001024 1 5",
               o_valid, o_alu_result, o_is_load, o_rd);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_is_load !== 1'b0 || o_is_write !== 1'b0) begin
      n_fail++;
      $display("FAIL add_drain: got valid=%b ld=%b wr=%b want 0 0 0", o_valid, o_is_load, o_is_write);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t_op [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13, 4'd9};
    logic [31:0] t_a  [12] = '{32'hFFFFFFFF, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAAAAAA,
                               32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h5, 32'h1};
    logic [31:0] t_b  [12] = '{32'h2, 32'h7, 32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000,
                               32'h24, 32'h1F, 32'h21, 32'h1, 32'h1, 32'h6, 32'hFFFFFFFF};
    logic [31:0] t_exp[12] = '{32'h00000001, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'h5555AAAA,
                               32'h00000010, 32'h00000001, 32'hC0000000, 32'h00000001, 32'h00000000,
                               32'h00000000, 32'h00000001};
    i_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 32'h0, 5'(i + 1), 1'b0, 1'b0, 1'b1);
      #1;
      n_tests++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, o_ready); end
      tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_alu_result !== t_exp[i] || o_rd !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got valid=%b res=%h rd=%0d want 1 %h %0d",
                 i, o_valid, o_alu_result, o_rd, t_exp[i], i + 1);
      end
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    int cyc;
    i_out_ready = 1'b1;
    drive(4'd10, 32'hFFFFFFFF, 32'h3, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1);
    tick();
    i_valid = 1'b1;
    i_alu_op = 4'd0;
    #1;
    for (int k = 0; k < 32; k++) begin
      n_tests++;
      if (o_busy !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_running[%0d]: got busy=%b ready=%b valid=%b want 1 0 0",
                 k, o_busy, o_ready, o_valid);
      end
      if (k < 31) tick();
    end
    i_valid = 1'b0;
    tick();
    n_tests++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'hFFFFFFFD || o_busy !== 1'b0 ||
        o_rd !== 5'd7 || o_is_write !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_result: got valid=%b res=%h busy=%b rd=%0d wr=%b want 1 fffffffd 0 7 1",
               o_valid, o_alu_result, o_busy, o_rd, o_is_write);
    end
    drive(4'd10, 32'h12345678, 32'h10, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_tests++;
    if (cyc !== 32 || o_alu_result !== 32'h23456780) begin
      n_fail++;
      $display("FAIL mul2_latency: got cycles=%0d res=%h want 32 23456780", cyc, o_alu_result);
    end
    tick();
  endtask

  task automatic test_stall();
    i_out_ready = 1'b0;
    drive(4'd0, 32'h200, 32'h4, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'd0, 32'h1, 32'h1, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_alu_result !== 32'h204 || o_write_data !== 32'hDEADBEEF ||
          o_is_store !== 1'b1 || o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b res=%h wd=%h st=%b ready=%b want 1 00000204 deadbeef 1 0",
                 k, o_valid, o_alu_result, o_write_data, o_is_store, o_ready);
      end
      tick();
    end
    i_out_ready = 1'b1;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_alu_result !== 32'h2 || o_rd !== 5'd9 ||
        o_is_store !== 1'b0 || o_is_write !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_replace: got valid=%b res=%h rd=%0d st=%b wr=%b want 1 00000002 9 0 1",
               o_valid, o_alu_result, o_rd, o_is_store, o_is_write);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_is_write !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got valid=%b wr=%b want 0 0", o_valid, o_is_write);
    end
  endtask

  task automatic test_flush();
    logic seen;
    i_out_ready = 1'b1;
    drive(4'd10, 32'h3, 32'h5, 32'h11, 5'd3, 1'b0, 1'b1, 1'b0);
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    n_tests++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", o_busy); end
    i_flush = 1'b1;
    drive(4'd0, 32'h1, 32'h1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", o_ready); end
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_is_store !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_abort: got busy=%b valid=%b st=%b want 0 0 0", o_busy, o_valid, o_is_store);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: got emitted=%b want 0", seen); end
    i_out_ready = 1'b0;
    drive(4'd0, 32'h7, 32'h8, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_out_ready = 1'b1;
    n_tests++;
    if (o_valid !== 1'b0 || o_is_write !== 1'b0) begin
      n_fail++; $display("FAIL flush_pending: got valid=%b wr=%b want 0 0", o_valid, o_is_write);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    int   cyc;
    i_out_ready = 1'b1;
    drive(4'd10, 32'h7, 32'h6, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_mul: got busy=%b valid=%b ready=%b want 0 0 0", o_busy, o_valid, o_ready);
    end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_result: got emitted=%b want 0", seen); end
    drive(4'd10, 32'h00010001, 32'h00010001, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_tests++;
    if (cyc !== 32 || o_alu_result !== 32'h00020001 || o_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL rst_cold_mul: got cycles=%0d res=%h rd=%0d want 32 00020001 6", cyc, o_alu_result, o_rd);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_stall();
    test_flush();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
